// File: rtl/disp_page_sched.sv
// Page scheduler for the seven-segment display. It captures up to four 128-bit result vectors
// and shows the selected one as eight 16-bit windows, with dwell-timed rotation, pause and step.
module disp_page_sched #(
    parameter int DWELL = 100000000,
    parameter int NSRC  = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NSRC*128-1:0]  src_data,
    input  logic [NSRC-1:0]      src_vld,
    input  logic                 btn_pause,
    input  logic                 btn_step,
    input  logic                 btn_src,
    output logic [15:0]          disp_word,
    output logic [2:0]           page,
    output logic [1:0]           src_sel,
    output logic [NSRC-1:0]      pend,
    output logic                 hold
);

    localparam int DW = $clog2(DWELL);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      page_reg, page_next;
    logic [1:0]      sel_reg, sel_next;
    logic [NSRC-1:0] pend_reg, pend_next;
    logic [DW-1:0]   dwell_reg, dwell_next;
    logic [15:0]     disp_reg;

    logic [127:0]    shadow [NSRC];
    logic [NSRC-1:0] sel_onehot;
    logic [NSRC-1:0] pend_cap;
    logic [1:0]      first_idx;
    logic [1:0]      rot_idx;
    logic [1:0]      cand;
    logic [1:0]      sel_inc;
    logic            found;
    logic [15:0]     window;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_shadow
        logic [127:0] data_reg;
        always_ff @(posedge clk or posedge clr) begin
            if (clr)
                data_reg <= '0;
            else if (src_vld[gi])
                data_reg <= src_data[128*gi +: 128];
        end
        assign shadow[gi] = data_reg;
    end

    // Page 0 is the most significant 16-bit word of the vector.
    assign window     = shadow[sel_reg][{~page_reg, 4'b0000} +: 16];
    assign sel_onehot = NSRC'(1) << sel_reg;
    assign pend_cap   = pend_reg | (src_vld & ~sel_onehot);
    assign sel_inc    = sel_reg + 2'd1;

    always_comb begin
        first_idx = '0;
        for (int k = NSRC - 1; k >= 0; k--)
            if (src_vld[k])
                first_idx = 2'(k);

        // Rotation target: first pending source after the current one, wrapping around.
        found   = 1'b0;
        rot_idx = sel_reg;
        cand    = sel_reg;
        for (int k = 1; k < NSRC; k++) begin
            cand = sel_reg + 2'(k);
            if (!found && pend_cap[cand]) begin
                found   = 1'b1;
                rot_idx = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        sel_next   = sel_reg;
        pend_next  = pend_reg;
        dwell_next = dwell_reg;
        case (state_reg)
            IDLE: begin
                if (|src_vld) begin
                    state_next = SHOW;
                    sel_next   = first_idx;
                    page_next  = '0;
                    dwell_next = '0;
                    pend_next  = (pend_reg | src_vld) & ~(NSRC'(1) << first_idx);
                end
            end
            default: begin
                pend_next = pend_cap;
                if (btn_src) begin
                    sel_next           = sel_inc;
                    page_next          = '0;
                    dwell_next         = '0;
                    pend_next[sel_inc] = 1'b0;
                end else begin
                    if (src_vld[sel_reg]) begin
                        page_next  = '0;
                        dwell_next = '0;
                    end else if (state_reg == SHOW) begin
                        if (dwell_reg == DWELL_LAST) begin
                            dwell_next = '0;
                            page_next  = page_reg + 3'd1;
                            if (page_reg == 3'd7 && found) begin
                                sel_next           = rot_idx;
                                pend_next[rot_idx] = 1'b0;
                            end
                        end else begin
                            dwell_next = dwell_reg + 1'b1;
                        end
                    end else if (btn_step) begin
                        page_next = page_reg + 3'd1;
                    end
                    // Pause acts after any page advance taken this cycle.
                    if (btn_pause) begin
                        if (state_reg == SHOW) begin
                            state_next = HOLD;
                        end else begin
                            state_next = SHOW;
                            dwell_next = '0;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            page_reg  <= '0;
            sel_reg   <= '0;
            pend_reg  <= '0;
            dwell_reg <= '0;
            disp_reg  <= '0;
        end else begin
            state_reg <= state_next;
            page_reg  <= page_next;
            sel_reg   <= sel_next;
            pend_reg  <= pend_next;
            dwell_reg <= dwell_next;
            disp_reg  <= (state_reg == IDLE) ? 16'h0000 : window;
        end
    end

    assign disp_word = disp_reg;
    assign page      = page_reg;
    assign src_sel   = sel_reg;
    assign pend      = pend_reg;
    assign hold      = (state_reg == HOLD);

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched with DWELL=4: expected display words go through a
// queue when stimulus is applied and are popped as the registered output appears.
module tb_disp_page_sched;

    logic         clk = 1'b0;
    logic         clr;
    logic [511:0] src_data;
    logic [3:0]   src_vld;
    logic         btn_pause, btn_step, btn_src;
    logic [15:0]  disp_word;
    logic [2:0]   page;
    logic [1:0]   src_sel;
    logic [3:0]   pend;
    logic         hold;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    localparam logic [127:0] V1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] V2  = 128'hA5A5_0001_0002_0003_0004_0005_0006_5A5A;
    localparam logic [127:0] V0  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] V0B = 128'hBEEF_9999_AAAA_BBBB_CCCC_DDDD_EEEE_F00D;
    localparam logic [127:0] V3  = 128'hCAFE_1234_0000_0000_0000_0000_0000_4321;

    disp_page_sched #(.DWELL(4), .NSRC(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .src_data  (src_data),
        .src_vld   (src_vld),
        .btn_pause (btn_pause),
        .btn_step  (btn_step),
        .btn_src   (btn_src),
        .disp_word (disp_word),
        .page      (page),
        .src_sel   (src_sel),
        .pend      (pend),
        .hold      (hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'h0, disp_word}, {16'h0, e});
        end
    endtask

    function automatic logic [15:0] wd(input logic [127:0] v, input int p);
        return v[127 - 16*p -: 16];
    endfunction

    task automatic set_cap(input int i, input logic [127:0] v);
        src_data[128*i +: 128] = v;
        src_vld[i] = 1'b1;
    endtask

    task automatic press_src();
        btn_src = 1'b1;
        tick();
        btn_src = 1'b0;
    endtask

    task automatic wait_page(input logic [2:0] t);
        int n;
        n = 0;
        while (page !== t && n < 200) begin
            tick();
            n++;
        end
        chk("wait_page", {29'h0, page}, {29'h0, t});
    endtask

    logic [15:0] w1 [8];

    initial begin
        w1 = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
        clr = 1'b1; src_data = '0; src_vld = '0;
        btn_pause = 1'b0; btn_step = 1'b0; btn_src = 1'b0;
        tick(); tick();
        clr = 1'b0;
        tick();
        chk("rst_disp", {16'h0, disp_word}, 32'h0);
        chk("rst_page", {29'h0, page}, 32'h0);
        chk("rst_sel",  {30'h0, src_sel}, 32'h0);
        chk("rst_pend", {28'h0, pend}, 32'h0);
        chk("rst_hold", {31'h0, hold}, 32'h0);

        // 1: first capture leaves IDLE and sweeps the eight windows
        set_cap(1, V1);
        tick();
        src_vld = '0;
        chk("s1_sel",  {30'h0, src_sel}, 32'd1);
        chk("s1_pend", {28'h0, pend}, 32'h0);
        for (int p = 0; p < 8; p++)
            for (int r = 0; r < 4; r++) exp_q.push_back(w1[p]);
        exp_q.push_back(w1[0]);
        exp_q.push_back(w1[0]);
        for (int k = 0; k < 34; k++) begin
            tick();
            chk_disp("s1_disp");
        end

        // 2: pending sources picked up in rotation order at each wrap
        set_cap(2, V2); tick(); src_vld = '0;
        set_cap(0, V0); tick(); src_vld = '0;
        chk("s2_pend", {28'h0, pend}, 32'b0101);
        wait_page(3'd7);
        wait_page(3'd0);
        chk("s2_rot1_sel",  {30'h0, src_sel}, 32'd2);
        chk("s2_rot1_pend", {28'h0, pend}, 32'b0001);
        exp_q.push_back(wd(V2, 0));
        tick();
        chk_disp("s2_rot1_disp");
        wait_page(3'd7);
        wait_page(3'd0);
        chk("s2_rot2_sel",  {30'h0, src_sel}, 32'd0);
        chk("s2_rot2_pend", {28'h0, pend}, 32'h0);

        // 3: pause, stepping with wrap, resume restarts dwell
        wait_page(3'd3);
        btn_pause = 1'b1; tick(); btn_pause = 1'b0;
        chk("s3_hold", {31'h0, hold}, 32'd1);
        chk("s3_page", {29'h0, page}, 32'd3);
        repeat (50) tick();
        chk("s3_page_held", {29'h0, page}, 32'd3);
        for (int k = 0; k < 6; k++) begin
            btn_step = 1'b1; tick(); btn_step = 1'b0;
            chk("s3_step_page", {29'h0, page}, 32'((4 + k) % 8));
        end
        chk("s3_sel", {30'h0, src_sel}, 32'd0);
        btn_pause = 1'b1; tick(); btn_pause = 1'b0;
        chk("s3_resume_hold", {31'h0, hold}, 32'd0);
        repeat (3) tick();
        chk("s3_dwell_page1", {29'h0, page}, 32'd1);
        tick();
        chk("s3_dwell_page2", {29'h0, page}, 32'd2);

        // 4: manual select wraps 3->0; capture of another source only flags it
        press_src(); press_src(); press_src();
        chk("s4_sel3", {30'h0, src_sel}, 32'd3);
        press_src();
        chk("s4_sel0",  {30'h0, src_sel}, 32'd0);
        chk("s4_page0", {29'h0, page}, 32'd0);
        set_cap(3, V3);
        exp_q.push_back(wd(V0, 0));
        tick();
        src_vld = '0;
        chk_disp("s4_disp");
        chk("s4_pend", {28'h0, pend}, 32'b1000);

        // 5: btn_src beats capture restart and dwell advance in the same cycle
        wait_page(3'd5);
        repeat (3) tick();
        chk("s5_page_last", {29'h0, page}, 32'd5);
        set_cap(0, V0B);
        btn_src = 1'b1;
        tick();
        src_vld = '0; btn_src = 1'b0;
        chk("s5_sel",  {30'h0, src_sel}, 32'd1);
        chk("s5_page", {29'h0, page}, 32'd0);
        chk("s5_pend", {28'h0, pend}, 32'b1000);
        press_src(); press_src(); press_src();
        exp_q.push_back(wd(V0B, 0));
        tick();
        chk_disp("s5_new_data");
        chk("s5_pend_clr", {28'h0, pend}, 32'h0);

        // 6: asynchronous clear from HOLD, then IDLE exit with simultaneous strobes
        wait_page(3'd6);
        btn_pause = 1'b1; tick(); btn_pause = 1'b0;
        chk("s6_hold", {31'h0, hold}, 32'd1);
        set_cap(1, V1); tick(); src_vld = '0;
        chk("s6_pend_pre", {28'h0, pend}, 32'b0010);
        clr = 1'b1;
        #1;
        chk("s6_clr_disp", {16'h0, disp_word}, 32'h0);
        chk("s6_clr_page", {29'h0, page}, 32'h0);
        chk("s6_clr_pend", {28'h0, pend}, 32'h0);
        chk("s6_clr_hold", {31'h0, hold}, 32'h0);
        tick();
        clr = 1'b0;
        repeat (5) tick();
        press_src();
        tick();
        chk("s6_idle_disp", {16'h0, disp_word}, 32'h0);
        chk("s6_idle_sel",  {30'h0, src_sel}, 32'h0);
        set_cap(2, V2); set_cap(3, V3);
        tick();
        src_vld = '0;
        chk("s6_exit_sel",  {30'h0, src_sel}, 32'd2);
        chk("s6_exit_pend", {28'h0, pend}, 32'b1000);
        chk("s6_exit_hold", {31'h0, hold}, 32'd0);
        exp_q.push_back(wd(V2, 0));
        tick();
        chk_disp("s6_exit_disp");
        press_src(); press_src();
        exp_q.push_back(16'h0000);
        tick();
        chk_disp("s6_shadow0_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
